rgbw_controller: RTL and testbench

Four-channel 8-bit PWM generator driving R, G, B and W LED outputs. It is the core behind the tt_um_thexeno_rgbw_controller top-level wrapper. A simple byte register port writes the per-channel duty values. Duties are double-buffered and take effect only at a PWM period boundary, so outputs never glitch.

---
 rtl/rgbw_controller.sv | 142 ++++++++++++++
 tb/tb_rgbw_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_controller.sv
// Four-channel 8-bit PWM LED controller with double-buffered duty registers.
// Optional master dimming register enabled by defining MASTER_DIM_EN.
module rgbw_controller #(
    parameter int PRESCALE = 1,
    parameter bit INVERT   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       wr_en,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       pwm_w,
    output logic       period_start
);

    localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);

    logic [7:0]    stage  [4];
    logic [7:0]    active [4];
    logic [7:0]    eff    [4];
    logic [7:0]    cnt;
    logic [PW-1:0] presc;
    logic [3:0]    pwm;
    logic          tick;
    logic          load;

`ifdef MASTER_DIM_EN
    logic [7:0] master;

    // Scale a duty by (master+1)/256; 255*256 still fits in 16 bits.
    function automatic logic [7:0] scale(input logic [7:0] duty, input logic [7:0] m);
        logic [15:0] prod;
        prod = {8'd0, duty} * ({8'd0, m} + 16'd1);
        return prod[15:8];
    endfunction
`endif

    assign tick = ena && (presc == PMAX);
    assign load = tick && (cnt == 8'hFF);

    assign pwm_r = pwm[0];
    assign pwm_g = pwm[1];
    assign pwm_b = pwm[2];
    assign pwm_w = pwm[3];

    // Register readback; unmapped addresses read as zero.
    always_comb begin
        rdata = 8'd0;
        case (addr)
            3'd0:    rdata = stage[0];
            3'd1:    rdata = stage[1];
            3'd2:    rdata = stage[2];
            3'd3:    rdata = stage[3];
`ifdef MASTER_DIM_EN
            3'd4:    rdata = master;
`endif
            default: rdata = 8'd0;
        endcase
    end

    // Duty value that will be latched into the active set at the next load.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
`ifdef MASTER_DIM_EN
            eff[i] = scale(stage[i], master);
`else
            eff[i] = stage[i];
`endif
        end
    end

    // Staging register writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                stage[i] <= 8'd0;
            end
        end else if (wr_en && (addr[2] == 1'b0)) begin
            stage[addr[1:0]] <= wdata;
        end
    end

`ifdef MASTER_DIM_EN
    // Master dimming register, full brightness out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            master <= 8'hFF;
        end else if (wr_en && (addr == 3'd4)) begin
            master <= wdata;
        end
    end
`endif

    // Prescaler and PWM period counter; both freeze while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            cnt   <= 8'd0;
        end else if (ena) begin
            if (tick) begin
                presc <= '0;
                cnt   <= cnt + 8'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Active duties update only at the period boundary; a same-cycle write
    // lands in staging and is picked up one period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                active[i] <= 8'd0;
            end
        end else if (load) begin
            for (int i = 0; i < 4; i++) begin
                active[i] <= eff[i];
            end
        end
    end

    // Registered compare outputs and period marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm          <= {4{INVERT}};
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pwm[i] <= ena ? ((cnt < active[i]) ^ INVERT) : INVERT;
            end
            period_start <= load;
        end
    end

endmodule

// File: tb/tb_rgbw_controller.sv
// Directed self-checking bench for rgbw_controller: register table plus
// period-level duty, double-buffer, enable, invert and reset sequences.
module tb_rgbw_controller;

    logic       clk = 1'b0;
    logic       rst, ena, wr_en;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd0, rd1, rd2;
    wire  [3:0] pw0, pw1, pw2;
    wire        ps0, ps1, ps2;

    int checks = 0;
    int errors = 0;

`ifdef MASTER_DIM_EN
    localparam logic [7:0] MRST = 8'hFF;
    localparam logic [7:0] M7F  = 8'h7F;
    localparam logic [7:0] MFF  = 8'hFF;
`else
    localparam logic [7:0] MRST = 8'h00;
    localparam logic [7:0] M7F  = 8'h00;
    localparam logic [7:0] MFF  = 8'h00;
`endif

    always #5 clk = ~clk;

    rgbw_controller #(.PRESCALE(1), .INVERT(1'b0)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rd0), .pwm_r(pw0[0]), .pwm_g(pw0[1]), .pwm_b(pw0[2]), .pwm_w(pw0[3]),
        .period_start(ps0));

    rgbw_controller #(.PRESCALE(1), .INVERT(1'b1)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rd1), .pwm_r(pw1[0]), .pwm_g(pw1[1]), .pwm_b(pw1[2]), .pwm_w(pw1[3]),
        .period_start(ps1));

    rgbw_controller #(.PRESCALE(3), .INVERT(1'b0)) u2 (
        .clk(clk), .rst(rst), .ena(ena), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rd2), .pwm_r(pw2[0]), .pwm_g(pw2[1]), .pwm_b(pw2[2]), .pwm_w(pw2[3]),
        .period_start(ps2));

    typedef struct {
        bit         we;
        logic [2:0] a;
        logic [7:0] d;
        logic [2:0] ra;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[14];

    function automatic logic [3:0] get_pw(input int sel);
        case (sel)
            0:       return pw0;
            1:       return pw1;
            default: return pw2;
        endcase
    endfunction

    function automatic logic get_ps(input int sel);
        case (sel)
            0:       return ps0;
            1:       return ps1;
            default: return ps2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic adv();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
    endtask

    task automatic wait_ps(input int sel, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            adv();
            if (get_ps(sel)) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("period_start_seen_dut%0d", sel), ok, 1);
    endtask

    // Called on the sample where period_start is high; counts high samples.
    task automatic measure(input int sel, input int len, input int wr_at,
                           input logic [2:0] wa, input logic [7:0] wd,
                           output int hr, output int hg, output int hb, output int hw,
                           output int nps);
        logic [3:0] p;
        hr = 0; hg = 0; hb = 0; hw = 0; nps = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) adv();
            p = get_pw(sel);
            hr += int'(p[0]);
            hg += int'(p[1]);
            hb += int'(p[2]);
            hw += int'(p[3]);
            nps += int'(get_ps(sel));
            if (i == wr_at) wr(wa, wd);
        end
    endtask

    initial begin
        int hr, hg, hb, hw, nps, lows, n, hi;
        bit found;

        vt[0]  = '{1'b0, 3'd0, 8'h00, 3'd4, MRST};
        vt[1]  = '{1'b1, 3'd2, 8'hA5, 3'd2, 8'hA5};
        vt[2]  = '{1'b1, 3'd6, 8'h11, 3'd6, 8'h00};
        vt[3]  = '{1'b0, 3'd0, 8'h00, 3'd2, 8'hA5};
        vt[4]  = '{1'b1, 3'd0, 8'd64, 3'd0, 8'd64};
        vt[5]  = '{1'b1, 3'd1, 8'd128, 3'd1, 8'd128};
        vt[6]  = '{1'b1, 3'd2, 8'd255, 3'd2, 8'd255};
        vt[7]  = '{1'b1, 3'd3, 8'd0, 3'd3, 8'd0};
        vt[8]  = '{1'b1, 3'd7, 8'h33, 3'd7, 8'h00};
        vt[9]  = '{1'b1, 3'd5, 8'h44, 3'd5, 8'h00};
        vt[10] = '{1'b1, 3'd4, 8'h7F, 3'd4, M7F};
        vt[11] = '{1'b1, 3'd4, 8'hFF, 3'd4, MFF};
        vt[12] = '{1'b0, 3'd0, 8'h00, 3'd0, 8'd64};
        vt[13] = '{1'b0, 3'd0, 8'h00, 3'd1, 8'd128};

        rst = 1'b1; ena = 1'b1; wr_en = 1'b0; addr = 3'd0; wdata = 8'd0;
        adv();
        adv();
        chk("reset_pwm", pw0, 4'h0);
        chk("reset_pwm_inv", pw1, 4'hF);
        chk("reset_period_start", ps0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            addr = 3'(i);
            #1;
            chk($sformatf("reset_rdata_%0d", i), rd0, 8'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            adv();
            if (vt[i].we) wr(vt[i].a, vt[i].d);
            adv();
            addr = vt[i].ra;
            #1;
            chk($sformatf("rdata_vec%0d", i), rd0, vt[i].exp);
            chk($sformatf("rdata_inv_vec%0d", i), rd1, vt[i].exp);
        end

        // Duty counts with R=64 G=128 B=255 W=0.
        wait_ps(0, 600);
        wait_ps(0, 300);
        measure(0, 256, -1, 3'd0, 8'd0, hr, hg, hb, hw, nps);
        chk("duty_r", hr, 64); chk("duty_g", hg, 128);
        chk("duty_b", hb, 255); chk("duty_w", hw, 0);
        chk("ps_once_per_period", nps, 1);
        adv();
        chk("ps_period_256", ps0, 1'b1);
        measure(1, 256, -1, 3'd0, 8'd0, hr, hg, hb, hw, nps);
        chk("inv_high_r", hr, 192); chk("inv_high_g", hg, 128);
        chk("inv_high_b", hb, 1);   chk("inv_high_w", hw, 256);

        wait_ps(2, 1000);
        measure(2, 768, -1, 3'd0, 8'd0, hr, hg, hb, hw, nps);
        chk("p3_duty_r", hr, 192); chk("p3_duty_g", hg, 384);
        chk("p3_duty_b", hb, 765); chk("p3_duty_w", hw, 0);
        chk("p3_ps_once", nps, 1);

        // Double buffering: mid-period write, then a write on the load tick.
        wait_ps(0, 300);
        measure(0, 256, 100, 3'd0, 8'd200, hr, hg, hb, hw, nps);
        chk("dbuf_current", hr, 64);
        adv();
        measure(0, 256, 255, 3'd0, 8'd30, hr, hg, hb, hw, nps);
        chk("dbuf_next", hr, 200);
        adv();
        measure(0, 256, -1, 3'd0, 8'd0, hr, hg, hb, hw, nps);
        chk("coincide_old", hr, 200);
        adv();
        measure(0, 256, -1, 3'd0, 8'd0, hr, hg, hb, hw, nps);
        chk("coincide_new", hr, 30);

        // Enable gap on the inverted instance with R=10.
        adv();
        wr(3'd0, 8'd10);
        wait_ps(1, 300);
        wait_ps(1, 300);
        lows = 0; n = 0; found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) begin
                adv();
                if (ps1) begin
                    found = 1'b1;
                    n = k;
                    break;
                end
            end
            if (!pw1[0]) lows++;
            if (k == 30) begin
                chk("ena_off_inv", pw1, 4'hF);
                chk("ena_off_pwm", pw0, 4'h0);
                chk("ena_off_ps", ps0, 1'b0);
            end
            if (k == 5) ena = 1'b0;
            if (k == 55) ena = 1'b1;
        end
        chk("ena_gap_ps_seen", found, 1'b1);
        chk("ena_gap_period_len", n, 306);
        chk("ena_gap_low_count", lows, 10);

`ifdef MASTER_DIM_EN
        wr(3'd4, 8'd127);
        adv();
        wr(3'd0, 8'd200);
        wait_ps(0, 400);
        wait_ps(0, 300);
        measure(0, 256, -1, 3'd0, 8'd0, hr, hg, hb, hw, nps);
        chk("master127_r", hr, 100); chk("master127_g", hg, 64);
        chk("master127_b", hb, 127); chk("master127_w", hw, 0);
        adv();
        wr(3'd4, 8'd0);
        wait_ps(0, 300);
        wait_ps(0, 300);
        measure(0, 256, -1, 3'd0, 8'd0, hr, hg, hb, hw, nps);
        chk("master0_r", hr, 0); chk("master0_b", hb, 0);
`endif

        // Reset mid-period clears everything; next period starts from zero.
        wait_ps(0, 400);
        repeat (77) adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        chk("midrst_pwm", pw0, 4'h0);
        chk("midrst_pwm_inv", pw1, 4'hF);
        chk("midrst_ps", ps0, 1'b0);
        addr = 3'd0;
        #1;
        chk("midrst_rdata_r", rd0, 8'd0);
        addr = 3'd4;
        #1;
        chk("midrst_rdata_master", rd0, MRST);
        hi = 0; n = 0; found = 1'b0;
        for (int k = 1; k < 400; k++) begin
            adv();
            if (ps0) begin
                found = 1'b1;
                n = k;
                break;
            end
            hi += int'(pw0[0]) + int'(pw0[1]) + int'(pw0[2]) + int'(pw0[3]);
        end
        chk("midrst_ps_seen", found, 1'b1);
        chk("midrst_first_period_len", n, 256);
        chk("midrst_all_off", hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
